ram_access_ctrl: RTL and testbench

Initiator-side controller that drives one `single_port_ram` instance on behalf of a PE or load/store client inside a CBG. It accepts read/write requests over a valid/ready handshake and turns them into `ena`/`wea`/`addr`/`din` strobes. It captures returned data on `read_valid`, buffers read data in a small in-order response FIFO with credit-based back-pressure, and sequences a flush of the RAM port on request.

---
 rtl/ram_access_ctrl_pkg.sv | 12 +
 rtl/rsp_fifo.sv | 55 +++++
 rtl/ram_access_ctrl.sv | 104 ++++++++++
 tb/tb_ram_access_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared constants and FSM encoding for the RAM access controller.
package ram_access_ctrl_pkg;

  localparam int unsigned A_W             = 11;
  localparam int unsigned RspDepthDefault = 2;

  typedef enum logic {
    StRun   = 1'b0,
    StFlush = 1'b1
  } rac_state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Small synchronous in-order FIFO holding read responses; clear empties it in one cycle.
module rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [Width-1:0]           wdata,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [Width-1:0]           head
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for one single-port RAM: FSM, inflight tracking, credit, response FIFO.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = A_W - 1,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RSP_DEPTH = RspDepthDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_flush,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_read_valid
);

  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);

  rac_state_e        state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [CntW:0]     occupancy;
  logic              in_run, credit, accept, rd_accept;
  logic              fifo_push, fifo_pop, fifo_clear;

  // Pops in the same cycle are not credited; keeps the credit path off rsp_ready.
  assign occupancy = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
  assign credit    = occupancy < (CntW + 1)'(RSP_DEPTH);
  assign in_run    = (state_q == StRun);
  assign req_ready = ~rst & in_run & ~flush & (req_we | credit);
  assign accept    = req_valid & req_ready;
  assign rd_accept = accept & ~req_we;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush) state_d = StFlush;
      StFlush: state_d = flush ? StFlush : StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (!in_run)             inflight_d = 1'b0;
    else if (rd_accept)      inflight_d = 1'b1;
    else if (ram_read_valid) inflight_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  // Returning data in the flush cycle is dropped along with the FIFO contents.
  assign fifo_push  = in_run & ram_read_valid;
  assign fifo_clear = ~in_run;
  assign fifo_pop   = rsp_valid & rsp_ready;

  rsp_fifo #(
    .Depth(RSP_DEPTH),
    .Width(DATA_W)
  ) u_rsp_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .clear(fifo_clear),
    .wdata(ram_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

  assign rsp_valid = ~rst & ~fifo_empty;
  assign rsp_rdata = rsp_valid ? fifo_head : '0;

  assign ram_ena   = accept;
  assign ram_wea   = accept & req_we;
  assign ram_addr  = accept ? req_addr : '0;
  assign ram_din   = accept ? req_wdata : '0;
  assign ram_flush = ~rst & ~in_run;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural single-port RAM on the RAM side.
module tb_ram_access_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk, rst, flush;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, ram_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, ram_din, ram_dout;
  logic          rsp_valid, rsp_ready;
  logic          ram_ena, ram_wea, ram_flush, ram_read_valid;

  int checks = 0;
  int errors = 0;

  ram_access_ctrl #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .RSP_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .ram_ena       (ram_ena),
    .ram_wea       (ram_wea),
    .ram_addr      (ram_addr),
    .ram_din       (ram_din),
    .ram_flush     (ram_flush),
    .ram_dout      (ram_dout),
    .ram_read_valid(ram_read_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle read latency, read_valid suppressed by flush.
  logic [DW-1:0] mem [2**AW];
  logic          rv_q;
  logic [DW-1:0] dout_q;
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addr] <= ram_din;
    if (ram_ena && !ram_wea) dout_q <= mem[ram_addr];
    rv_q <= ram_ena & ~ram_wea & ~ram_flush;
  end
  assign ram_read_valid = rv_q & ~ram_flush;
  assign ram_dout       = dout_q;

  always @(posedge clk) begin
    if (rst === 1'b0 && dut.fifo_push && dut.fifo_full) begin
      errors++;
      $display("FAIL fifo_overflow: push into full response FIFO at %0t", $time);
    end
  end

  typedef struct {
    logic          valid;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rr;
    logic          exp_ready;
    logic          exp_rv;
    logic [DW-1:0] exp_rdata;
    logic          exp_ena;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic v, logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic rr,
                              logic er, logic erv, logic [DW-1:0] ed, logic ee);
    vec_t t;
    t.valid = v; t.we = we; t.addr = a; t.wdata = d; t.rr = rr;
    t.exp_ready = er; t.exp_rv = erv; t.exp_rdata = ed; t.exp_ena = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic rr, input logic fl);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr; flush = fl;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 10'd3; req_wdata = 32'h1234_5678; rsp_ready = 1'b0;

    vecs[0]  = mk(1, 1, 5, 32'hDEAD_BEEF, 1, 1, 0, 0, 1);
    vecs[1]  = mk(1, 0, 5, 0, 1, 1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 1, 1, 32'hDEAD_BEEF, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) vecs[5+i] = mk(1, 1, AW'(i), DW'(i), 0, 1, 0, 0, 1);
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[10] = mk(1, 0, 1, 0, 0, 1, 0, 0, 1);
    vecs[11] = mk(1, 0, 2, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(1, 0, 2, 0, 0, 0, 1, 0, 0);
    vecs[13] = mk(1, 1, 7, 32'h77, 0, 1, 1, 0, 1);
    vecs[14] = mk(1, 0, 2, 0, 1, 0, 1, 0, 0);
    vecs[15] = mk(1, 0, 2, 0, 1, 1, 1, 1, 1);
    vecs[16] = mk(1, 0, 3, 0, 1, 1, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 1, 0, 1, 2, 0);
    vecs[18] = mk(0, 0, 0, 0, 1, 1, 1, 3, 0);
    vecs[19] = mk(1, 0, 7, 0, 1, 1, 0, 0, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 1, 1, 1, 32'h77, 0);
    vecs[22] = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);

    // Reset values, with a write offered to show it is not taken.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_ram_ena", 32'(ram_ena), 0);
    chk("rst_ram_wea", 32'(ram_wea), 0);
    chk("rst_ram_flush", 32'(ram_flush), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_din", ram_din, 0);
    adv();
    rst = 1'b0;

    for (int i = 0; i < 23; i++) begin
      apply(vecs[i].valid, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rr, 1'b0);
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rv));
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_ram_ena", i), 32'(ram_ena), 32'(vecs[i].exp_ena));
      if (vecs[i].exp_ena) begin
        chk($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_ram_wea", i), 32'(ram_wea), 32'(vecs[i].we));
      end
      adv();
    end

    // Flush mid-stream: read 1 at N-1, flush at N with read 2 offered.
    apply(1, 0, 1, 0, 0, 0);
    chk("fl_nm1_ready", 32'(req_ready), 1);
    adv();
    apply(1, 0, 2, 0, 0, 1);
    chk("fl_n_ready", 32'(req_ready), 0);
    chk("fl_n_ena", 32'(ram_ena), 0);
    adv();
    apply(0, 0, 0, 0, 0, 0);
    chk("fl_n1_ram_flush", 32'(ram_flush), 1);
    chk("fl_n1_ready", 32'(req_ready), 0);
    chk("fl_n1_ena", 32'(ram_ena), 0);
    chk("fl_n1_rsp_valid", 32'(rsp_valid), 1);
    chk("fl_n1_rsp_rdata", rsp_rdata, 1);
    adv();
    apply(1, 0, 3, 0, 1, 0);
    chk("fl_n2_ram_flush", 32'(ram_flush), 0);
    chk("fl_n2_rsp_valid", 32'(rsp_valid), 0);
    chk("fl_n2_ready", 32'(req_ready), 1);
    chk("fl_n2_ena", 32'(ram_ena), 1);
    adv();
    apply(0, 0, 0, 0, 1, 0);
    chk("fl_n3_rsp_valid", 32'(rsp_valid), 0);
    adv();
    apply(0, 0, 0, 0, 1, 0);
    chk("fl_n4_rsp_valid", 32'(rsp_valid), 1);
    chk("fl_n4_rsp_rdata", rsp_rdata, 3);
    adv();
    apply(0, 0, 0, 0, 1, 0);
    chk("fl_n5_rsp_valid", 32'(rsp_valid), 0);
    adv();

    // Flush held for two cycles keeps the FSM in FLUSH.
    apply(0, 0, 0, 0, 1, 1);
    chk("flh0_ready", 32'(req_ready), 0);
    adv();
    apply(1, 1, 9, 32'hAA, 1, 1);
    chk("flh1_ram_flush", 32'(ram_flush), 1);
    chk("flh1_ready", 32'(req_ready), 0);
    adv();
    apply(1, 1, 9, 32'hAA, 1, 0);
    chk("flh2_ram_flush", 32'(ram_flush), 1);
    chk("flh2_ready", 32'(req_ready), 0);
    adv();
    apply(1, 1, 9, 32'hAA, 1, 0);
    chk("flh3_ram_flush", 32'(ram_flush), 0);
    chk("flh3_ready", 32'(req_ready), 1);
    chk("flh3_ena", 32'(ram_ena), 1);
    adv();

    // Reset (with flush) while one response is queued and another is in flight.
    apply(1, 0, 0, 0, 0, 0);
    chk("rm0_ready", 32'(req_ready), 1);
    adv();
    apply(1, 0, 1, 0, 0, 0);
    chk("rm1_ready", 32'(req_ready), 1);
    adv();
    rst = 1'b1;
    apply(1, 0, 2, 0, 0, 1);
    chk("rm2_ready", 32'(req_ready), 0);
    chk("rm2_ena", 32'(ram_ena), 0);
    chk("rm2_rsp_valid", 32'(rsp_valid), 0);
    chk("rm2_rsp_rdata", rsp_rdata, 0);
    chk("rm2_ram_flush", 32'(ram_flush), 0);
    adv();
    rst = 1'b0;
    apply(0, 0, 0, 0, 1, 0);
    chk("rm3_ready", 32'(req_ready), 1);
    chk("rm3_rsp_valid", 32'(rsp_valid), 0);
    chk("rm3_ram_flush", 32'(ram_flush), 0);
    adv();
    apply(0, 0, 0, 0, 1, 0);
    chk("rm4_rsp_valid", 32'(rsp_valid), 0);
    adv();
    apply(0, 0, 0, 0, 1, 0);
    chk("rm5_rsp_valid", 32'(rsp_valid), 0);
    adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
